// File: rtl/mouse_event_bridge.sv
// Mouse event bridge: queues packets from the mouse transceiver in a small
// circular FIFO and exposes them to the processor through an 8-byte register
// window, with a level interrupt that re-asserts while events remain unread.
`timescale 1ns/1ps
module mouse_event_bridge #(
    parameter logic [7:0] BASE_ADDR = 8'hA0,
    parameter int         DEPTH     = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] MOUSE_STATUS,
    input  logic [7:0] MOUSE_X,
    input  logic [7:0] MOUSE_Y,
    input  logic       MOUSE_INTR,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic [7:0] BUS_DATA_IN,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_OUT_EN,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } intState_t;

    logic [19:0]      fifoMem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [3:0]       count;
    logic [3:0]       countNext;
    logic             overflow;
    logic             enable;
    intState_t        state;
    intState_t        stateNext;

    logic [7:0]  offset;
    logic        pushReq;
    logic        popReq;
    logic        ctrlWrite;
    logic        flush;
    logic        isEmpty;
    logic        isFull;
    logic        popOk;
    logic        pushOk;
    logic        dropEvent;
    logic        readHit;
    logic [19:0] headEntry;
    logic [7:0]  readValue;
    logic        unusedDataBits;

    // Offset relative to the window base; wraps naturally so any base works.
    assign offset = BUS_ADDR - BASE_ADDR;

    assign unusedDataBits = ^BUS_DATA_IN[7:3];

    // Decode bus strobes and decide which FIFO operations actually happen.
    // A flush discards a coinciding push; a full FIFO only accepts a push
    // when a pop frees a slot in the same cycle.
    always_comb begin
        pushReq   = MOUSE_INTR && enable;
        popReq    = BUS_WE && (offset == 8'd4);
        ctrlWrite = BUS_WE && (offset == 8'd5);
        flush     = ctrlWrite && BUS_DATA_IN[2];
        isEmpty   = (count == 4'd0);
        isFull    = (count == 4'(DEPTH));
        popOk     = popReq && !isEmpty;
        pushOk    = pushReq && !flush && (!isFull || popOk);
        dropEvent = pushReq && !flush && isFull && !popOk;
        if (flush) begin
            countNext = 4'd0;
        end else begin
            countNext = count + {3'b000, pushOk} - {3'b000, popOk};
        end
    end

    // Pointer and occupancy bookkeeping for the circular event queue.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= 4'd0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= 4'd0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popOk) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= countNext;
        end
    end

    // Event storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge CLK) begin
        if (pushOk && !RESET) begin
            fifoMem[wrPtr] <= {MOUSE_STATUS, MOUSE_X, MOUSE_Y};
        end
    end

    // Control flags: a dropped event in the same cycle as a clear keeps
    // overflow set, since the newer loss must not be hidden.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow <= 1'b0;
            enable   <= 1'b1;
        end else begin
            if (ctrlWrite) begin
                enable <= BUS_DATA_IN[0];
            end
            if (dropEvent) begin
                overflow <= 1'b1;
            end else if (ctrlWrite && BUS_DATA_IN[1]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Read mux for the four readable registers; head fields read as zero when empty.
    always_comb begin
        headEntry = fifoMem[rdPtr];
        readHit   = !BUS_WE && (offset < 8'd4);
        readValue = 8'h00;
        case (offset[1:0])
            2'd0: readValue = isEmpty ? 8'h00 : {4'h0, headEntry[19:16]};
            2'd1: readValue = isEmpty ? 8'h00 : headEntry[15:8];
            2'd2: readValue = isEmpty ? 8'h00 : headEntry[7:0];
            default: readValue = {overflow, enable, 2'b00, count};
        endcase
    end

    // Registered read port: one cycle from address to data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BUS_DATA_OUT    <= 8'h00;
            BUS_DATA_OUT_EN <= 1'b0;
        end else if (readHit) begin
            BUS_DATA_OUT    <= readValue;
            BUS_DATA_OUT_EN <= 1'b1;
        end else begin
            BUS_DATA_OUT    <= 8'h00;
            BUS_DATA_OUT_EN <= 1'b0;
        end
    end

    // Interrupt state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Interrupt next-state: an acknowledge drops the request for one cycle,
    // and IDLE returns to PENDING whenever events are still queued, so unread
    // events get re-signalled. A flush always forces IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (countNext != 4'd0) begin
                    stateNext = PENDING;
                end
            end
            PENDING: begin
                if (BUS_INTERRUPT_ACK && !pushOk) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (flush) begin
            stateNext = IDLE;
        end
    end

    assign BUS_INTERRUPT_RAISE = (state == PENDING);

endmodule

// File: tb/tb_mouse_event_bridge.sv
// Self-checking bench for mouse_event_bridge: a directed vector table for the
// documented scenarios, then randomized traffic checked against a queue model.
`timescale 1ns/1ps
module tb_mouse_event_bridge;

    localparam logic [7:0] BASE  = 8'hA0;
    localparam int         DEPTH = 4;

    logic       CLK;
    logic       RESET;
    logic [3:0] MOUSE_STATUS;
    logic [7:0] MOUSE_X;
    logic [7:0] MOUSE_Y;
    logic       MOUSE_INTR;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic [7:0] BUS_DATA_IN;
    logic [7:0] BUS_DATA_OUT;
    logic       BUS_DATA_OUT_EN;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        logic       rst;
        logic       intr;
        logic [3:0] st;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] addr;
        logic       we;
        logic [7:0] din;
        logic       ack;
        logic [7:0] expData;
        logic       expEn;
        logic       expRaise;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: queued events, flags and whether an interrupt is owed.
    logic [19:0] mq[$];
    logic        mOvf;
    logic        mEn;
    logic        mPend;
    logic [7:0]  mData;
    logic        mOutEn;

    mouse_event_bridge #(
        .BASE_ADDR(BASE),
        .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .MOUSE_STATUS(MOUSE_STATUS),
        .MOUSE_X(MOUSE_X),
        .MOUSE_Y(MOUSE_Y),
        .MOUSE_INTR(MOUSE_INTR),
        .BUS_ADDR(BUS_ADDR),
        .BUS_WE(BUS_WE),
        .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_DATA_OUT(BUS_DATA_OUT),
        .BUS_DATA_OUT_EN(BUS_DATA_OUT_EN),
        .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK(BUS_INTERRUPT_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock of model behaviour: read result from the pre-edge contents,
    // then control write, pop/push and the interrupt obligation.
    task automatic modelStep(input logic rst, input logic intr, input logic [3:0] st,
                             input logic [7:0] x, input logic [7:0] y, input logic [7:0] addr,
                             input logic we, input logic [7:0] din, input logic ack);
        logic [7:0] off;
        logic popReq, ctrlW, flush, popped, pushed;
        off = addr - BASE;
        if (rst) begin
            mq.delete();
            mOvf   = 1'b0;
            mEn    = 1'b1;
            mPend  = 1'b0;
            mData  = 8'h00;
            mOutEn = 1'b0;
        end else begin
            mOutEn = !we && (off < 8'd4);
            mData  = 8'h00;
            if (mOutEn) begin
                case (off)
                    8'd0: if (mq.size() > 0) mData = {4'h0, mq[0][19:16]};
                    8'd1: if (mq.size() > 0) mData = mq[0][15:8];
                    8'd2: if (mq.size() > 0) mData = mq[0][7:0];
                    default: mData = {mOvf, mEn, 2'b00, 4'(mq.size())};
                endcase
            end
            popReq = we && (off == 8'd4);
            ctrlW  = we && (off == 8'd5);
            flush  = ctrlW && din[2];
            if (ctrlW && din[1]) mOvf = 1'b0;
            if (flush) begin
                mq.delete();
                mPend = 1'b0;
            end else begin
                popped = popReq && (mq.size() > 0);
                pushed = 1'b0;
                if (intr && mEn) begin
                    if (mq.size() < DEPTH || popped) pushed = 1'b1;
                    else mOvf = 1'b1;
                end
                if (popped) void'(mq.pop_front());
                if (pushed) mq.push_back({st, x, y});
                if (mPend) begin
                    if (ack && !pushed) mPend = 1'b0;
                end else if (mq.size() > 0) begin
                    mPend = 1'b1;
                end
            end
            if (ctrlW) mEn = din[0];
        end
    endtask

    // Drive one cycle of inputs, advance the model, and sample just after the edge.
    task automatic applyStimulus(input logic rst, input logic intr, input logic [3:0] st,
                                 input logic [7:0] x, input logic [7:0] y, input logic [7:0] addr,
                                 input logic we, input logic [7:0] din, input logic ack);
        RESET             = rst;
        MOUSE_INTR        = intr;
        MOUSE_STATUS      = st;
        MOUSE_X           = x;
        MOUSE_Y           = y;
        BUS_ADDR          = addr;
        BUS_WE            = we;
        BUS_DATA_IN       = din;
        BUS_INTERRUPT_ACK = ack;
        modelStep(rst, intr, st, x, y, addr, we, din, ack);
        @(posedge CLK);
        #1;
    endtask

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic rst, input logic intr, input logic [3:0] st,
                          input logic [7:0] x, input logic [7:0] y, input logic [7:0] addr,
                          input logic we, input logic [7:0] din, input logic ack,
                          input logic [7:0] ed, input logic ee, input logic er);
        vec_t v;
        v.rst = rst; v.intr = intr; v.st = st; v.x = x; v.y = y;
        v.addr = addr; v.we = we; v.din = din; v.ack = ack;
        v.expData = ed; v.expEn = ee; v.expRaise = er;
        vecs.push_back(v);
    endtask

    initial begin
        logic       rRst, rIntr, rWe, rAck;
        logic [3:0] rSt;
        logic [7:0] rX, rY, rAddr, rDin;

        // Reset, then a single event read back through all four registers
        addVec(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'h9, 8'd80, 8'd60, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA0, 1'b0, 8'h00, 1'b0, 8'h09, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA1, 1'b0, 8'h00, 1'b0, 8'h50, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA2, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA4, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA5, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
        // Overflow: five pushes into four slots, then clear
        for (int i = 1; i <= 5; i++)
            addVec(1'b0, 1'b1, 4'(i), 8'h10 + 8'(i), 8'h20 + 8'(i), 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'hC4, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA1, 1'b0, 8'h00, 1'b0, 8'h11, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA5, 1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 1'b1);
        // Push and pop together while full
        addVec(1'b0, 1'b1, 4'h6, 8'h16, 8'h26, 8'hA4, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA2, 1'b0, 8'h00, 1'b0, 8'h22, 1'b1, 1'b1);
        // Acknowledge with events left, then drain and acknowledge
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA5, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'h7, 8'h17, 8'h27, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b1, 4'h8, 8'h18, 8'h28, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA4, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA4, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0);
        // Flush in the same cycle as a push
        addVec(1'b0, 1'b1, 4'h9, 8'h19, 8'h29, 8'hA5, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        // Reset with three entries stored and a packet arriving
        addVec(1'b0, 1'b1, 4'h1, 8'h11, 8'h21, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b1, 4'h2, 8'h12, 8'h22, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b1, 4'h3, 8'h13, 8'h23, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h43, 1'b1, 1'b1);
        addVec(1'b1, 1'b1, 4'hF, 8'hFF, 8'hFF, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA4, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA3, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'hA0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] directed vectors: %0d", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].intr, vecs[i].st, vecs[i].x, vecs[i].y,
                          vecs[i].addr, vecs[i].we, vecs[i].din, vecs[i].ack);
            checkOutput($sformatf("vec%0d data", i), BUS_DATA_OUT, vecs[i].expData);
            checkOutput($sformatf("vec%0d outEn", i), {7'b0, BUS_DATA_OUT_EN}, {7'b0, vecs[i].expEn});
            checkOutput($sformatf("vec%0d raise", i), {7'b0, BUS_INTERRUPT_RAISE}, {7'b0, vecs[i].expRaise});
        end

        $display("[TB] randomized traffic against reference model");
        for (int i = 0; i < 800; i++) begin
            rRst  = ($urandom_range(0, 99) == 0);
            rIntr = ($urandom_range(0, 9) < 4);
            rSt   = 4'($urandom);
            rX    = 8'($urandom);
            rY    = 8'($urandom);
            if ($urandom_range(0, 9) == 0) rAddr = 8'($urandom);
            else rAddr = BASE + 8'($urandom_range(0, 7));
            rWe   = ($urandom_range(0, 9) < 4);
            rDin  = 8'($urandom);
            if (rAddr == BASE + 8'd5) begin
                rDin[0] = ($urandom_range(0, 7) != 0);
                rDin[2] = ($urandom_range(0, 7) == 0);
            end
            rAck  = ($urandom_range(0, 9) < 2);
            applyStimulus(rRst, rIntr, rSt, rX, rY, rAddr, rWe, rDin, rAck);
            checkOutput($sformatf("rnd%0d data", i), BUS_DATA_OUT, mData);
            checkOutput($sformatf("rnd%0d outEn", i), {7'b0, BUS_DATA_OUT_EN}, {7'b0, mOutEn});
            checkOutput($sformatf("rnd%0d raise", i), {7'b0, BUS_INTERRUPT_RAISE}, {7'b0, mPend});
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
